// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter for the shared single-ported instruction/data memory
//
// Serialises IF fetches and MEM loads/stores onto one memory port, one transaction
// at a time. Data wins over fetch, and a pending data access wins over halt.
// Parks the core in HALT on halt_req or on a memory timeout. Only reset leaves HALT.
//
// Ports:
//   clk, rst                 core clock (rising edge), asynchronous active-low reset
//   if_req/if_addr           fetch request from IF; if_valid/if_rdata complete it
//   dm_req/dm_we/dm_be/
//   dm_addr/dm_wdata         load/store request from MEM; dm_valid/dm_rdata complete it
//   halt_req                 ECALL/EBREAK reached MEM
//   stall_if, stall_mem      pipeline freeze controls
//   halted, bus_err          sticky status (bus_err = timeout)
//   mem_*                    registered request to memory; mem_rdata/mem_ready come back
module unified_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  input  logic        halt_req,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        halted,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // A TIMEOUT of 0 disables the watchdog. In that case the counter never moves.
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          busy;
  logic          timeout_hit;

  assign busy = (state == S_DATA) || (state == S_FETCH);

  // mem_ready in the threshold cycle takes precedence: timeout_hit requires !mem_ready.
  assign timeout_hit = TO_EN && busy && !mem_ready && (wait_cnt == CNT_LAST);

  assign dm_valid  = (state == S_DATA)  && mem_ready;
  assign if_valid  = (state == S_FETCH) && mem_ready;
  assign dm_rdata  = mem_rdata;
  assign if_rdata  = mem_rdata;
  assign halted    = (state == S_HALT);

  assign stall_mem = dm_req && !dm_valid;
  assign stall_if  = (if_req && !if_valid) || stall_mem || halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (dm_req) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= S_DATA;
          end else if (halt_req) begin
            state <= S_HALT;
          end else if (if_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= 4'b1111;
            mem_addr <= if_addr;
            state    <= S_FETCH;
          end
        end
        S_DATA, S_FETCH: begin
          // Returning to IDLE on completion creates a one-cycle bubble. A requester
          // that still asserts req in its completion cycle is not issued twice.
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
